// File: rtl/xillybus_bridge_pkg.sv
// Shared types and width helpers for the Xillybus <-> ap_fifo bridge.
package xillybus_bridge_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_PAD, ST_DRAIN, ST_EOF} up_state_t;

  function automatic int unsigned ratio(input int unsigned data_w, input int unsigned ap_w);
    return data_w / ap_w;
  endfunction

  // Lane counters keep at least one bit so RATIO==1 still elaborates.
  function automatic int unsigned lane_bits(input int unsigned r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/xillybus_sync_fifo.sv
// Single-clock FIFO with registered read data and a synchronous clear.
module xillybus_sync_fifo #(
  parameter int unsigned W          = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [W-1:0]          mem_q [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   cnt_q;
  logic                  wr_ok, rd_ok;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  // Each side is judged on the pre-edge count, so a pop never makes room for a same-cycle push.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (DEPTH_LOG2 + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (rd_ok && !clr) begin
      dout <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/xillybus_ap_fifo_bridge.sv
// Xillybus stream pair to HLS ap_fifo bridge: dn path unpacks words to lanes, up path packs lanes with pad/EOF.
module xillybus_ap_fifo_bridge
  import xillybus_bridge_pkg::*;
#(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned AP_W       = 32,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic              user_w_write_open,
  input  logic              user_w_write_wren,
  input  logic [DATA_W-1:0] user_w_write_data,
  output logic              user_w_write_full,
  input  logic              user_r_read_open,
  input  logic              user_r_read_rden,
  output logic [DATA_W-1:0] user_r_read_data,
  output logic              user_r_read_empty,
  output logic              user_r_read_eof,
  output logic [AP_W-1:0]   dn_dout,
  output logic              dn_empty_n,
  input  logic              dn_read,
  input  logic [AP_W-1:0]   up_din,
  output logic              up_full_n,
  input  logic              up_write,
  input  logic              up_done
);

  localparam int unsigned RATIO  = ratio(DATA_W, AP_W);
  localparam int unsigned LANE_W = lane_bits(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic unused_write_open;
  assign unused_write_open = user_w_write_open;

  // ---------------- Dn path ----------------
  logic              dn_fifo_empty, dn_fifo_rd;
  logic [DATA_W-1:0] dn_word;
  logic              dn_valid_q, dn_pend_q;
  logic [LANE_W-1:0] dn_lane_q;
  logic              dn_take, dn_last, dn_fill;

  xillybus_sync_fifo #(.W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_dn_fifo (
    .clk(bus_clk), .rst(bus_rst), .clr(1'b0),
    .wr_en(user_w_write_wren), .din(user_w_write_data), .full(user_w_write_full),
    .rd_en(dn_fifo_rd), .dout(dn_word), .empty(dn_fifo_empty)
  );

  // The FIFO's registered dout doubles as the unpacker word; a last-lane read pops the
  // next word on the same edge, while a refill from idle takes one extra settle cycle.
  assign dn_take    = dn_read && dn_valid_q;
  assign dn_last    = (dn_lane_q == LAST_LANE);
  assign dn_fill    = !dn_valid_q && !dn_pend_q && !dn_fifo_empty;
  assign dn_fifo_rd = dn_fill || (dn_take && dn_last && !dn_fifo_empty);
  assign dn_empty_n = dn_valid_q;
  assign dn_dout    = dn_word[dn_lane_q*AP_W +: AP_W];

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      dn_valid_q <= 1'b0;
      dn_pend_q  <= 1'b0;
      dn_lane_q  <= '0;
    end else begin
      dn_pend_q <= dn_fill;
      if (dn_pend_q) begin
        dn_valid_q <= 1'b1;
      end else if (dn_take) begin
        if (dn_last) begin
          dn_lane_q  <= '0;
          dn_valid_q <= !dn_fifo_empty;
        end else begin
          dn_lane_q <= dn_lane_q + LANE_W'(1);
        end
      end
    end
  end

  // ---------------- Up path ----------------
  up_state_t         state_q, state_d;
  logic              open_q, open_fall;
  logic              up_fifo_full, up_fifo_empty, up_fifo_wr;
  logic [DATA_W-1:0] up_fifo_din, up_word;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              up_acc, up_last, pad_push;

  xillybus_sync_fifo #(.W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_up_fifo (
    .clk(bus_clk), .rst(bus_rst), .clr(open_fall),
    .wr_en(up_fifo_wr), .din(up_fifo_din), .full(up_fifo_full),
    .rd_en(user_r_read_rden), .dout(user_r_read_data), .empty(up_fifo_empty)
  );

  assign open_fall         = open_q && !user_r_read_open;
  assign up_full_n         = (state_q == ST_RUN) && !up_fifo_full;
  assign up_acc            = up_write && up_full_n;
  assign up_last           = (lane_q == LAST_LANE);
  assign pad_push          = (state_q == ST_PAD) && !up_fifo_full;
  assign up_fifo_wr        = (up_acc && up_last) || pad_push;
  assign user_r_read_empty = up_fifo_empty;
  assign user_r_read_eof   = (state_q == ST_EOF) && up_fifo_empty;

  always_comb begin
    up_word = pack_q;
    up_word[(RATIO-1)*AP_W +: AP_W] = up_din;
    up_fifo_din = pad_push ? pack_q : up_word;
  end

  // Completed or padded words leave pack_q cleared, so a pad word is zero above the partial lanes.
  always_comb begin
    pack_d = pack_q;
    lane_d = lane_q;
    if (pad_push || (up_acc && up_last)) begin
      pack_d = '0;
      lane_d = '0;
    end else if (up_acc) begin
      pack_d[lane_q*AP_W +: AP_W] = up_din;
      lane_d = lane_q + LANE_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (up_done) state_d = (lane_d != '0) ? ST_PAD : ST_DRAIN;
      ST_PAD:   if (!up_fifo_full) state_d = ST_DRAIN;
      ST_DRAIN: if (up_fifo_empty) state_d = ST_EOF;
      ST_EOF:   state_d = ST_EOF;
      default:  state_d = ST_RUN;
    endcase
    if (open_fall) state_d = ST_RUN;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q <= ST_RUN;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      open_q  <= user_r_read_open;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst || open_fall) begin
      pack_q <= '0;
      lane_q <= '0;
    end else begin
      pack_q <= pack_d;
      lane_q <= lane_d;
    end
  end

endmodule
